led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Parametrised board front-panel controller: synchronises and debounces pushbuttons, synchronises slide switches, and drives an LED bank with one of four selectable animated patterns at a switch-controlled speed. Sits directly under the board top level, between the raw KEY/SW pins and the LED pins.

## Interface
- LED_W, 8, LED bank width (>=2)
- SW_W, 4, switch count
- KEY_W, 2, pushbutton count (>=2; KEY[0] and KEY[1] have functions, others debounced only)
- DEB_CYCLES, 16, consecutive stable cycles needed to accept a key change (>=2)
- TICK_DIV, 8, base prescaler period in clk cycles (>=1)
- PWM_DUTY, 8, on-slots out of 16, range 0..16 (used only with LED_PWM_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- SW  in  SW_W  raw slide switches, asynchronous
- KEY  in  KEY_W  raw pushbuttons, asynchronous, pressed = 0
- LED  out  LED_W  registered LED drive, 1 = lit

## Operation
- Reset values: LED = 0, mode = MIRROR, run = 1, pattern = 0, prescaler = 0, all debounced keys = 1 (released).
- SW and KEY pass through 2-flop synchronisers (reset 0 for SW, 1 for KEY).
- Debounce per key: counter clears whenever synced value equals stable value; otherwise increments; on reaching DEB_CYCLES-1 the stable value takes the synced value and counter clears. Press = one-cycle pulse on stable 1->0.
- Modes (2-bit): 0 MIRROR, 1 COUNT, 2 ROTATE, 3 BOUNCE.
- KEY[0] press: mode <= mode+1, 3 wraps to 0; pattern loads mode's initial value (COUNT 0, ROTATE/BOUNCE 1 with direction left); prescaler clears.
- KEY[1] press: run toggles. run = 0 freezes prescaler and pattern; LED holds.
- Prescaler: limit = TICK_DIV*(SW_sync+1)-1; counts 0..limit, tick pulse on the limit cycle, then 0. If SW changes so counter > limit, counter wraps to 0 next cycle without tick.
- MIRROR: LED follows SW_sync zero-extended/truncated to LED_W every cycle; ticks ignored.
- COUNT: pattern +1 per tick, mod 2^LED_W.
- ROTATE: rotate left per tick, bit LED_W-1 wraps to bit 0.
- BOUNCE: single lit bit shifts per tick; direction reverses on reaching bit LED_W-1 (next moves right) and bit 0 (next moves left); never leaves the bank.
- Simultaneous KEY[0] and KEY[1] press: both take effect. Mode change and tick same cycle: mode change wins, tick discarded.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Timing
- Raw key stable change to press pulse: 2 + DEB_CYCLES cycles; press to mode register: 1 cycle; mode to LED: 1 cycle.
- Tick to LED update: 1 cycle (pattern register then LED register).
- SW change to LED in MIRROR: 3 cycles (2 sync + output register).
- Glitches shorter than DEB_CYCLES cycles produce no press.

## Configuration
- LED_PWM_EN defined: 4-bit free-running PWM counter (reset 0); LED = pattern when pwm_cnt < PWM_DUTY, else 0; PWM_DUTY 16 = always on, 0 = always off. Output still registered.
- Not defined: no PWM counter; LED = pattern directly (registered); PWM_DUTY ignored.

## Structure
- Package led_ctrl_pkg: mode enum (MIRROR, COUNT, ROTATE, BOUNCE), mode count, PWM counter width, initial pattern constants.
- Sub-module key_debounce (synchroniser + counter + press pulse, parameter DEB_CYCLES), instantiated KEY_W times via generate.

## Test plan
- Reset with SW=4'b1010, KEY=2'b11 -> LED=0 during reset; 3 cycles after release LED=8'b00001010 (MIRROR).
- DEB_CYCLES=4: KEY[0] low 3 cycles then high -> mode unchanged; low 10 cycles -> mode=COUNT, LED=0 then increments.
- TICK_DIV=2, SW=0, ROTATE -> LED 0x01,0x02,...,0x80,0x01 changing every 2 cycles; SW=1 -> every 4 cycles.
- BOUNCE, LED_W=8 -> sequence 0x01..0x80, then 0x40..0x01, then 0x02; press KEY[1] -> LED frozen; press again -> resumes from frozen value.
- KEY[0] and KEY[1] pressed same cycle in COUNT -> mode=ROTATE, run=0, LED=0x01 held.
- LED_PWM_EN, PWM_DUTY=4, MIRROR SW=4'hF -> LED=0x0F for 4 of every 16 cycles, 0 otherwise.

Source files
------------

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types and constants for the front-panel LED pattern controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MIRROR = 2'd0,
    COUNT  = 2'd1,
    ROTATE = 2'd2,
    BOUNCE = 2'd3
  } mode_t;

  localparam int MODE_CNT   = 4;
  localparam int PWM_W      = 4;
  localparam int INIT_COUNT = 0;
  localparam int INIT_SHIFT = 1;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'((int'(m) + 1) % MODE_CNT);
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter and press pulse (stable 1->0).
module key_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          key_p0, key_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
      press  <= 1'b0;
      // key_p1 -> stable: accept only after DEB_CYCLES consecutive differing samples
      if (key_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= key_p1;
        cnt    <= '0;
        press  <= ~key_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Front-panel controller: debounced keys pick one of four LED animations paced by SW.
// Define LED_PWM_EN to dim the LED bank with a 16-slot PWM of PWM_DUTY on-slots.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int SW_W       = 4,
  parameter int KEY_W      = 2,
  parameter int DEB_CYCLES = 16,
  parameter int TICK_DIV   = 8,
  parameter int PWM_DUTY   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW_W-1:0]  SW,
  input  logic [KEY_W-1:0] KEY,
  output logic [LED_W-1:0] LED
);

  localparam int MAX_LIM = TICK_DIV * (2 ** SW_W);
  localparam int PS_W    = $clog2(MAX_LIM) + 1;
  localparam int MW      = (SW_W < LED_W) ? SW_W : LED_W;

  logic [SW_W-1:0]  sw_p0, sw_p1;
  logic [KEY_W-1:0] key_stable, press;
  logic             key_unused;
  mode_t            mode;
  logic             run, dir_left, tick;
  logic [LED_W-1:0] pattern, sw_ext, led_src;
  logic [PS_W-1:0]  presc, limit;

  function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
    case (m)
      MIRROR:  return '0;
      COUNT:   return LED_W'(INIT_COUNT);
      default: return LED_W'(INIT_SHIFT);
    endcase
  endfunction

  for (genvar g = 0; g < KEY_W; g++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key    (KEY[g]),
      .stable (key_stable[g]),
      .press  (press[g])
    );
  end
  assign key_unused = ^key_stable;

  // SW -> sw_p0 -> sw_p1 synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= SW;
      sw_p1 <= sw_p0;
    end
  end

  assign limit = PS_W'(TICK_DIV * (int'(sw_p1) + 1) - 1);
  assign tick  = (presc == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= MIRROR;
      run      <= 1'b1;
      presc    <= '0;
      pattern  <= '0;
      dir_left <= 1'b1;
    end else begin
      if (press[1]) run <= ~run;
      // A mode change swallows any tick landing in the same cycle.
      if (press[0]) begin
        mode     <= next_mode(mode);
        pattern  <= init_pattern(next_mode(mode));
        dir_left <= 1'b1;
        presc    <= '0;
      end else if (run) begin
        presc <= (presc >= limit) ? '0 : presc + 1'b1;
        if (tick) begin
          case (mode)
            COUNT:  pattern <= pattern + 1'b1;
            ROTATE: pattern <= {pattern[LED_W-2:0], pattern[LED_W-1]};
            BOUNCE: begin
              if (dir_left) begin
                pattern <= pattern << 1;
                if (pattern[LED_W-2]) dir_left <= 1'b0;
              end else begin
                pattern <= pattern >> 1;
                if (pattern[1]) dir_left <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    sw_ext         = '0;
    sw_ext[MW-1:0] = sw_p1[MW-1:0];
  end

  assign led_src = (mode == MIRROR) ? sw_ext : pattern;

  // pattern/sw_p1 -> LED output register
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      LED     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      LED     <= (int'(pwm_cnt) < PWM_DUTY) ? led_src : '0;
    end
  end
`else
  logic pwm_unused;
  assign pwm_unused = (PWM_DUTY != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) LED <= '0;
    else        LED <= led_src;
  end
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: expected LED values are queued and popped as the LED updates.
module tb_led_pattern_ctrl;

  localparam int LED_W = 8;
  localparam int SW_W  = 4;
  localparam int KEY_W = 2;
  localparam int DEB   = 4;
  localparam int TDIV  = 2;
  localparam int DUTY  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [SW_W-1:0]  SW;
  logic [KEY_W-1:0] KEY;
  logic [LED_W-1:0] LED;

  int n_tests = 0;
  int n_fail  = 0;
  logic [LED_W-1:0] exp_q[$];

  led_pattern_ctrl #(
    .LED_W(LED_W), .SW_W(SW_W), .KEY_W(KEY_W),
    .DEB_CYCLES(DEB), .TICK_DIV(TDIV), .PWM_DUTY(DUTY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .KEY(KEY), .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the masked keys low long enough to debounce, then release and let them settle.
  task automatic press_keys(input logic [1:0] mask);
    KEY = ~mask;
    step(10);
    KEY = 2'b11;
    step(10);
  endtask

  task automatic wait_change(input int bound, output bit ok, output int cyc);
    logic [LED_W-1:0] prev;
    prev = LED;
    ok   = 1'b0;
    cyc  = 0;
    while (cyc < bound && !ok) begin
      step(1);
      cyc++;
      if (LED !== prev) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [LED_W-1:0] e;
    rst_n = 1'b0;
    SW    = 4'b1010;
    KEY   = 2'b11;
    step(3);
    n_tests++;
    if (LED !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold: LED=%h expected %h", LED, 8'h00);
    end
    rst_n = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h0A);
    while (exp_q.size() > 0) begin
      step(1);
      e = exp_q.pop_front();
      n_tests++;
      if (LED !== e) begin
        n_fail++;
        $display("FAIL reset_mirror: LED=%h expected %h", LED, e);
      end
    end
  endtask

  task automatic test_debounce;
    logic [LED_W-1:0] e;
    bit ok;
    int cyc;
    KEY = 2'b10;
    step(3);
    KEY = 2'b11;
    for (int i = 0; i < 15; i++) exp_q.push_back(8'h0A);
    while (exp_q.size() > 0) begin
      step(1);
      e = exp_q.pop_front();
      n_tests++;
      if (LED !== e) begin
        n_fail++;
        $display("FAIL glitch_no_press: LED=%h expected %h", LED, e);
      end
    end
    // Mode register lands 7 cycles after the raw edge, LED one cycle later.
    KEY = 2'b10;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h0A);
    exp_q.push_back(8'h00);
    while (exp_q.size() > 0) begin
      step(1);
      e = exp_q.pop_front();
      n_tests++;
      if (LED !== e) begin
        n_fail++;
        $display("FAIL press_latency: LED=%h expected %h", LED, e);
      end
    end
    step(2);
    KEY = 2'b11;
    step(10);
    n_tests++;
    if (LED !== 8'h00) begin
      n_fail++;
      $display("FAIL count_init: LED=%h expected %h", LED, 8'h00);
    end
    SW = 4'h0;
    for (int v = 1; v <= 5; v++) exp_q.push_back(LED_W'(v));
    for (int i = 0; exp_q.size() > 0; i++) begin
      wait_change(100, ok, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || LED !== e || (i > 0 && cyc != 2)) begin
        n_fail++;
        $display("FAIL count_step: LED=%h expected %h (ok=%0d cycles=%0d, want 2)", LED, e, ok, cyc);
      end
    end
  endtask

  task automatic test_rotate;
    logic [LED_W-1:0] e;
    bit ok;
    int cyc;
    SW = 4'hF;
    step(4);
    press_keys(2'b01);
    n_tests++;
    if (LED !== 8'h01) begin
      n_fail++;
      $display("FAIL rotate_init: LED=%h expected %h", LED, 8'h01);
    end
    SW = 4'h0;
    for (int k = 1; k < 8; k++) exp_q.push_back(8'h01 << k);
    exp_q.push_back(8'h01);
    for (int i = 0; exp_q.size() > 0; i++) begin
      wait_change(100, ok, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || LED !== e || (i > 0 && cyc != 2)) begin
        n_fail++;
        $display("FAIL rotate_fast: LED=%h expected %h (ok=%0d cycles=%0d, want 2)", LED, e, ok, cyc);
      end
    end
    SW = 4'h1;
    for (int k = 1; k < 5; k++) exp_q.push_back(8'h01 << k);
    for (int i = 0; exp_q.size() > 0; i++) begin
      wait_change(100, ok, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || LED !== e || (i > 0 && cyc != 4)) begin
        n_fail++;
        $display("FAIL rotate_slow: LED=%h expected %h (ok=%0d cycles=%0d, want 4)", LED, e, ok, cyc);
      end
    end
  endtask

  task automatic test_bounce;
    logic [LED_W-1:0] e;
    logic [LED_W-1:0] seq [16];
    bit ok;
    int cyc;
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    SW = 4'hF;
    step(4);
    press_keys(2'b01);
    n_tests++;
    if (LED !== 8'h01) begin
      n_fail++;
      $display("FAIL bounce_init: LED=%h expected %h", LED, 8'h01);
    end
    SW = 4'h0;
    foreach (seq[k]) exp_q.push_back(seq[k]);
    for (int i = 0; exp_q.size() > 0; i++) begin
      wait_change(100, ok, cyc);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || LED !== e || (i > 0 && cyc != 2)) begin
        n_fail++;
        $display("FAIL bounce_step: LED=%h expected %h (ok=%0d cycles=%0d, want 2)", LED, e, ok, cyc);
      end
    end
    SW = 4'hF;
    exp_q.push_back(8'h08);
    wait_change(100, ok, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || LED !== e) begin
      n_fail++;
      $display("FAIL bounce_slow: LED=%h expected %h (ok=%0d)", LED, e, ok);
    end
    press_keys(2'b10);
    wait_change(40, ok, cyc);
    n_tests++;
    if (ok || LED !== 8'h08) begin
      n_fail++;
      $display("FAIL bounce_freeze: LED=%h expected %h held (changed=%0d)", LED, 8'h08, ok);
    end
    press_keys(2'b10);
    exp_q.push_back(8'h10);
    wait_change(100, ok, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || LED !== e) begin
      n_fail++;
      $display("FAIL bounce_resume: LED=%h expected %h (ok=%0d)", LED, e, ok);
    end
  endtask

  task automatic test_simultaneous;
    logic [LED_W-1:0] e;
    bit ok;
    int cyc;
    press_keys(2'b01);
    n_tests++;
    if (LED !== 8'h0F) begin
      n_fail++;
      $display("FAIL wrap_mirror: LED=%h expected %h", LED, 8'h0F);
    end
    press_keys(2'b01);
    n_tests++;
    if (LED !== 8'h00) begin
      n_fail++;
      $display("FAIL reenter_count: LED=%h expected %h", LED, 8'h00);
    end
    press_keys(2'b11);
    n_tests++;
    if (LED !== 8'h01) begin
      n_fail++;
      $display("FAIL both_keys: LED=%h expected %h", LED, 8'h01);
    end
    wait_change(40, ok, cyc);
    n_tests++;
    if (ok || LED !== 8'h01) begin
      n_fail++;
      $display("FAIL both_keys_hold: LED=%h expected %h held (changed=%0d)", LED, 8'h01, ok);
    end
    press_keys(2'b10);
    exp_q.push_back(8'h02);
    wait_change(100, ok, cyc);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || LED !== e) begin
      n_fail++;
      $display("FAIL both_keys_resume: LED=%h expected %h (ok=%0d)", LED, e, ok);
    end
  endtask

  task automatic test_reset_mid;
    logic [LED_W-1:0] e;
    SW = 4'h5;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (LED !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: LED=%h expected %h", LED, 8'h00);
    end
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h05);
    while (exp_q.size() > 0) begin
      step(1);
      e = exp_q.pop_front();
      n_tests++;
      if (LED !== e) begin
        n_fail++;
        $display("FAIL post_reset_mirror: LED=%h expected %h", LED, e);
      end
    end
  endtask

  task automatic test_pwm;
    int lit;
    int bad;
    SW = 4'hF;
    step(5);
    lit = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (LED === 8'h0F) lit++;
      else if (LED !== 8'h00) bad++;
    end
    n_tests++;
    if (lit != 2 * DUTY || bad != 0) begin
      n_fail++;
      $display("FAIL pwm_duty: lit=%0d other=%0d expected lit=%0d other=0", lit, bad, 2 * DUTY);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
`ifdef LED_PWM_EN
    test_pwm;
`else
    test_debounce;
    test_rotate;
    test_bounce;
    test_simultaneous;
    test_reset_mid;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
